// File: rtl/tt_design_sel_ctrl.sv
// Design-select controller for the shared tt_top I/O spine: synchronises the raw select
// pads, steps the design address and gates spine enable so the address never moves under it.
module tt_design_sel_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int N_DESIGNS   = 250,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_rst_n_i,
  input  logic              sel_inc_i,
  input  logic              ena_i,
  output logic [ADDR_W-1:0] spine_addr_o,
  output logic              spine_ena_o,
  output logic              busy_o,
  output logic              inc_err_o,
  output logic [1:0]        dbg_state_o  // 0 IDLE, 1 SETTLE, 2 ACTIVE, 3 DRAIN
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_DESIGNS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
  logic [SYNC_STAGES-1:0] inc_sync_q, inc_sync_d;
  logic [SYNC_STAGES-1:0] ena_sync_q, ena_sync_d;
  logic                   inc_prev_q, inc_prev_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;

  logic              s_sel_rst_n;
  logic              s_inc;
  logic              s_ena;
  logic              inc_pulse;
  logic              addr_ev;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_target;

  // Select-reset chain clears to 0, i.e. the pad reads as asserted until it has synchronised.
  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], sel_rst_n_i};
    inc_sync_d = {inc_sync_q[SYNC_STAGES-2:0], sel_inc_i};
    ena_sync_d = {ena_sync_q[SYNC_STAGES-2:0], ena_i};
    inc_prev_d = s_inc;
  end

  assign s_sel_rst_n = rst_sync_q[SYNC_STAGES-1];
  assign s_inc       = inc_sync_q[SYNC_STAGES-1];
  assign s_ena       = ena_sync_q[SYNC_STAGES-1];
  assign inc_pulse   = s_inc & ~inc_prev_q;

  // A held select-reset is only an event while the address is still non-zero, so holding
  // the pad low costs a single drain and then lets the design re-enable at address 0.
  assign addr_inc    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
  assign addr_target = s_sel_rst_n ? addr_inc : '0;
  assign addr_ev     = s_sel_rst_n ? inc_pulse : (addr_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
      inc_sync_q <= '0;
      ena_sync_q <= '0;
      inc_prev_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      ena_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      inc_sync_q <= inc_sync_d;
      ena_sync_q <= ena_sync_d;
      inc_prev_q <= inc_prev_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      ena_q      <= ena_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (addr_ev) addr_d = addr_target;
        if (s_ena) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (addr_ev) addr_d = addr_target;
        if (!s_ena) begin
          state_d = ST_IDLE;
        end else if (addr_ev) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The enabled design must see its address unchanged, so the event is parked in pend.
      ST_ACTIVE: begin
        if (addr_ev) begin
          pend_d  = addr_target;
          state_d = ST_DRAIN;
        end else if (!s_ena) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        addr_d  = s_sel_rst_n ? pend_q : '0;
        if (inc_pulse) err_d = 1'b1;
        state_d = s_ena ? ST_SETTLE : ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    ena_d  = (state_d == ST_ACTIVE);
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_DRAIN);
  end

  assign spine_addr_o = addr_q;
  assign spine_ena_o  = ena_q;
  assign busy_o       = busy_q;
  assign inc_err_o    = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_tt_design_sel_ctrl.sv
// Bench for tt_design_sel_ctrl: directed scenarios plus random pad activity, with every
// output change checked in order and in time against a behavioural model.
module tb_tt_design_sel_ctrl;

  localparam int ADDR_W      = 10;
  localparam int N_DESIGNS   = 250;
  localparam int SYNC_STAGES = 2;
  localparam int SETTLE_CYC  = 4;
  localparam int OW          = ADDR_W + 3;
  localparam int EW          = 32 + OW;

  logic              clk;
  logic              rst_n;
  logic              sel_rst_n_i;
  logic              sel_inc_i;
  logic              ena_i;
  logic [ADDR_W-1:0] spine_addr_o;
  logic              spine_ena_o;
  logic              busy_o;
  logic              inc_err_o;
  logic [1:0]        dbg_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  tt_design_sel_ctrl #(
    .ADDR_W(ADDR_W), .N_DESIGNS(N_DESIGNS),
    .SYNC_STAGES(SYNC_STAGES), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sel_rst_n_i(sel_rst_n_i), .sel_inc_i(sel_inc_i), .ena_i(ena_i),
    .spine_addr_o(spine_addr_o), .spine_ena_o(spine_ena_o),
    .busy_o(busy_o), .inc_err_o(inc_err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Pads reach the decision logic SYNC_STAGES clocks late; the model keeps that delay as a
  // queue and tracks the mode as "enabled / draining / settle cycles left".
  logic [EW-1:0] exp_q[$];
  bit            q_r[$];
  bit            q_i[$];
  bit            q_e[$];
  int unsigned   m_addr;
  int unsigned   m_pend;
  bit            m_en;
  bit            m_drain;
  bit            m_err;
  bit            m_prev_inc;
  int            m_left;
  logic [OW-1:0] m_last = '0;

  task automatic model_step();
    bit sr, si, se, pulse, ev;
    int unsigned tgt;
    sr = q_r.pop_front();
    si = q_i.pop_front();
    se = q_e.pop_front();
    q_r.push_back(sel_rst_n_i);
    q_i.push_back(sel_inc_i);
    q_e.push_back(ena_i);
    pulse      = si && !m_prev_inc;
    m_prev_inc = si;
    tgt = sr ? (m_addr + 1) % N_DESIGNS : 0;
    ev  = sr ? pulse : (m_addr != 0);
    if (m_drain) begin
      if (pulse) m_err = 1'b1;
      m_addr  = sr ? m_pend : 0;
      m_drain = 1'b0;
      m_left  = se ? SETTLE_CYC : -1;
    end else if (m_en) begin
      if (ev) begin
        m_pend  = tgt;
        m_en    = 1'b0;
        m_drain = 1'b1;
      end else if (!se) begin
        m_en = 1'b0;
      end
    end else if (m_left > 0) begin
      if (ev) m_addr = tgt;
      if (!se) m_left = -1;
      else if (ev) m_left = SETTLE_CYC;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_left = -1;
          m_en   = 1'b1;
        end
      end
    end else begin
      if (ev) m_addr = tgt;
      if (se) m_left = SETTLE_CYC;
    end
  endtask

  task automatic model_emit();
    logic [OW-1:0] cur;
    cur = {ADDR_W'(m_addr), m_en, (m_drain || m_left > 0), m_err};
    if (cur !== m_last) begin
      exp_q.push_back({32'($time), cur});
      m_last = cur;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr = 0; m_pend = 0; m_en = 1'b0; m_drain = 1'b0; m_err = 1'b0;
      m_prev_inc = 1'b0; m_left = -1;
      q_r.delete(); q_i.delete(); q_e.delete();
      for (int k = 0; k < SYNC_STAGES; k++) begin
        q_r.push_back(1'b0);
        q_i.push_back(1'b0);
        q_e.push_back(1'b0);
      end
    end else begin
      model_step();
    end
    model_emit();
  end

  // ---------------- monitor / scoreboard ----------------
  bit            mon_en = 1'b0;
  logic [OW-1:0] mon_last = '0;
  logic          mon_rst_prev = 1'b0;
  int unsigned   win_lo = 0;

  always @(negedge clk) begin
    logic [OW-1:0] cur;
    logic [EW-1:0] e;
    int unsigned   e_t;
    if (mon_en) begin
      cur = {spine_addr_o, spine_ena_o, busy_o, inc_err_o};
      if (cur !== mon_last) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_change: got addr=%0d ena=%0b busy=%0b err=%0b at %0t, model expected no change",
                   cur[OW-1:3], cur[2], cur[1], cur[0], $time);
        end else begin
          e   = exp_q.pop_front();
          e_t = e[EW-1:OW];
          if (e[OW-1:0] !== cur || e_t <= win_lo) begin
            n_fail++;
            $display("FAIL out_change: got addr=%0d ena=%0b busy=%0b err=%0b at %0t, need addr=%0d ena=%0b busy=%0b err=%0b changed at %0t",
                     cur[OW-1:3], cur[2], cur[1], cur[0], $time,
                     e[OW-1:3], e[2], e[1], e[0], e_t);
          end
        end
        if (rst_n && mon_rst_prev && cur[OW-1:3] != mon_last[OW-1:3]) begin
          n_cmp++;
          if (cur[2] || mon_last[2]) begin
            n_fail++;
            $display("FAIL addr_invariant: addr %0d->%0d with ena now=%0b prev=%0b at %0t, need both 0",
                     mon_last[OW-1:3], cur[OW-1:3], cur[2], mon_last[2], $time);
          end
        end
      end
      mon_last     = cur;
      mon_rst_prev = rst_n;
      win_lo       = 32'($time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic inc_pad();
    sel_inc_i = 1'b1;
    tick(2);
    sel_inc_i = 1'b0;
    tick(2);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst_n       = 1'b0;
    sel_rst_n_i = 1'b1;
    sel_inc_i   = 1'b0;
    ena_i       = 1'b0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    check("reset_addr", spine_addr_o, 0);
    check("reset_ena", spine_ena_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_err", inc_err_o, 0);

    // three increments while disabled
    repeat (3) inc_pad();
    tick(4);
    check("inc3_addr", spine_addr_o, 3);
    check("inc3_ena", spine_ena_o, 0);

    // enable latency
    ena_i = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      lat++;
      if (spine_ena_o) break;
    end
    check("ena_latency", lat, SYNC_STAGES + SETTLE_CYC + 1);

    // increment while active: drain, move, re-settle
    inc_pad();
    tick(12);
    check("active_inc_addr", spine_addr_o, 4);
    check("active_inc_ena", spine_ena_o, 1);

    // walk to the last address and wrap
    ena_i = 1'b0;
    tick(4);
    repeat (N_DESIGNS - 1 - 4) inc_pad();
    tick(4);
    check("last_addr", spine_addr_o, N_DESIGNS - 1);
    inc_pad();
    tick(4);
    check("wrap_addr", spine_addr_o, 0);

    // select-reset held low while active at address 7
    repeat (7) inc_pad();
    ena_i = 1'b1;
    tick(12);
    check("pre_selrst_addr", spine_addr_o, 7);
    check("pre_selrst_ena", spine_ena_o, 1);
    sel_rst_n_i = 1'b0;
    tick(14);
    check("selrst_addr", spine_addr_o, 0);
    check("selrst_ena", spine_ena_o, 1);
    check("selrst_busy", busy_o, 0);
    sel_rst_n_i = 1'b1;
    tick(4);

    // increment landing in the drain cycle is dropped and flagged
    inc_pad();
    tick(10);
    check("pre_drop_addr", spine_addr_o, 1);
    check("pre_drop_err", inc_err_o, 0);
    sel_rst_n_i = 1'b0;
    tick(1);
    sel_inc_i = 1'b1;
    tick(2);
    sel_inc_i = 1'b0;
    tick(8);
    sel_rst_n_i = 1'b1;
    tick(10);
    check("drop_err", inc_err_o, 1);
    check("drop_addr", spine_addr_o, 0);

    // two increment edges two cycles apart while active
    sel_inc_i = 1'b1; tick(1);
    sel_inc_i = 1'b0; tick(1);
    sel_inc_i = 1'b1; tick(1);
    sel_inc_i = 1'b0; tick(14);

    // async reset in the middle of settling at address 5
    ena_i = 1'b0;
    sel_rst_n_i = 1'b0;
    tick(4);
    sel_rst_n_i = 1'b1;
    tick(4);
    repeat (5) inc_pad();
    ena_i = 1'b1;
    tick(5);
    check("settle_addr", spine_addr_o, 5);
    check("settle_busy", busy_o, 1);
    check("settle_ena", spine_ena_o, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr", spine_addr_o, 0);
    check("async_rst_ena", spine_ena_o, 0);
    check("async_rst_busy", busy_o, 0);
    check("async_rst_err", inc_err_o, 0);
    check("async_rst_state", dbg_state_o, 0);
    tick(3);
    rst_n = 1'b1;
    tick(4);

    // random pad activity
    for (int it = 0; it < 300; it++) begin
      sel_rst_n_i = ($urandom_range(0, 7) != 0);
      ena_i       = ($urandom_range(0, 3) != 0);
      sel_inc_i   = $urandom_range(0, 1);
      tick($urandom_range(1, 6));
    end
    sel_inc_i   = 1'b0;
    sel_rst_n_i = 1'b1;
    tick(20);

    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL missing_change: got no change, need addr=%0d ena=%0b busy=%0b err=%0b from %0t",
               e[OW-1:3], e[2], e[1], e[0], e[EW-1:OW]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
